// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and default widths for the EX/MEM pipeline register
package pipe_pkg;

  localparam int PIPE_DATA_W     = 32;
  localparam int PIPE_REG_ADDR_W = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic zero;
  } exmem_ctrl_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one negedge EX/MEM register slot with valid, hold and kill
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W     = PIPE_DATA_W,
  parameter int REG_ADDR_W = PIPE_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_hold,
  input  logic                  i_kill,
  input  logic                  i_valid,
  input  exmem_ctrl_t           i_ctrl,
  input  logic [DATA_W-1:0]     i_alu_res,
  input  logic [DATA_W-1:0]     i_write_data,
  input  logic [REG_ADDR_W-1:0] i_reg_dst,
  output logic                  o_valid,
  output exmem_ctrl_t           o_ctrl,
  output logic [DATA_W-1:0]     o_alu_res,
  output logic [DATA_W-1:0]     o_write_data,
  output logic [REG_ADDR_W-1:0] o_reg_dst
);

  logic                  r_valid;
  exmem_ctrl_t           r_ctrl;
  logic [DATA_W-1:0]     r_alu_res;
  logic [DATA_W-1:0]     r_write_data;
  logic [REG_ADDR_W-1:0] r_reg_dst;

  // Killed slots still load their data; only the valid bit is dropped.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_alu_res    <= '0;
      r_write_data <= '0;
      r_reg_dst    <= '0;
    end else if (!i_hold) begin
      r_valid      <= i_valid & ~i_kill;
      r_ctrl       <= i_ctrl;
      r_alu_res    <= i_alu_res;
      r_write_data <= i_write_data;
      r_reg_dst    <= i_reg_dst;
    end
  end

  assign o_valid      = r_valid;
  assign o_ctrl       = r_ctrl;
  assign o_alu_res    = r_alu_res;
  assign o_write_data = r_write_data;
  assign o_reg_dst    = r_reg_dst;

endmodule

// File: rtl/exmem_pipe_reg.sv
// rtl/exmem_pipe_reg.sv - multi-slot EX/MEM pipeline register with stall, flush and bubble gating
module exmem_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = PIPE_DATA_W,
  parameter int REG_ADDR_W  = PIPE_REG_ADDR_W,
  parameter int STAGES      = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hit,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic                   reg_write,
  input  logic                   mem_to_reg,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic                   branch,
  input  logic                   zero,
  input  logic [DATA_W-1:0]      alu_res,
  input  logic [DATA_W-1:0]      write_data,
  input  logic [REG_ADDR_W-1:0]  reg_dst,
  output logic                   out_valid,
  output logic                   reg_write_out,
  output logic                   mem_to_reg_out,
  output logic                   mem_read_out,
  output logic                   mem_write_out,
  output logic                   branch_out,
  output logic                   zero_out,
  output logic [DATA_W-1:0]      alu_res_out,
  output logic [DATA_W-1:0]      write_data_out,
  output logic [REG_ADDR_W-1:0]  reg_dst_out,
  output logic                   pcsrc,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic                   r_flush_pending;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_hold;
  logic                   w_kill;

  // Index 0 is the incoming EX bundle; index g+1 is the output of slot g.
  logic                  w_valid      [STAGES+1];
  exmem_ctrl_t           w_ctrl       [STAGES+1];
  logic [DATA_W-1:0]     w_alu_res    [STAGES+1];
  logic [DATA_W-1:0]     w_write_data [STAGES+1];
  logic [REG_ADDR_W-1:0] w_reg_dst    [STAGES+1];

  assign w_hold = ~hit;
  assign w_kill = flush | r_flush_pending;

  assign w_valid[0]           = in_valid;
  assign w_ctrl[0].reg_write  = reg_write;
  assign w_ctrl[0].mem_to_reg = mem_to_reg;
  assign w_ctrl[0].mem_read   = mem_read;
  assign w_ctrl[0].mem_write  = mem_write;
  assign w_ctrl[0].branch     = branch;
  assign w_ctrl[0].zero       = zero;
  assign w_alu_res[0]         = alu_res;
  assign w_write_data[0]      = write_data;
  assign w_reg_dst[0]         = reg_dst;

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    pipe_slot #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
    ) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_hold       (w_hold),
      .i_kill       (w_kill),
      .i_valid      (w_valid[g]),
      .i_ctrl       (w_ctrl[g]),
      .i_alu_res    (w_alu_res[g]),
      .i_write_data (w_write_data[g]),
      .i_reg_dst    (w_reg_dst[g]),
      .o_valid      (w_valid[g+1]),
      .o_ctrl       (w_ctrl[g+1]),
      .o_alu_res    (w_alu_res[g+1]),
      .o_write_data (w_write_data[g+1]),
      .o_reg_dst    (w_reg_dst[g+1])
    );
  end

  // A flush seen while stalled is remembered and applied on the next advancing edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pending <= 1'b0;
    end else if (!hit) begin
      if (flush) r_flush_pending <= 1'b1;
    end else begin
      r_flush_pending <= 1'b0;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!hit && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  // Side-effect controls are masked on bubbles; data and status pass through.
  assign out_valid      = w_valid[STAGES];
  assign reg_write_out  = w_ctrl[STAGES].reg_write & out_valid;
  assign mem_read_out   = w_ctrl[STAGES].mem_read  & out_valid;
  assign mem_write_out  = w_ctrl[STAGES].mem_write & out_valid;
  assign branch_out     = w_ctrl[STAGES].branch    & out_valid;
  assign mem_to_reg_out = w_ctrl[STAGES].mem_to_reg;
  assign zero_out       = w_ctrl[STAGES].zero;
  assign alu_res_out    = w_alu_res[STAGES];
  assign write_data_out = w_write_data[STAGES];
  assign reg_dst_out    = w_reg_dst[STAGES];
  assign pcsrc          = out_valid & w_ctrl[STAGES].branch & w_ctrl[STAGES].zero;
  assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// tb/tb_exmem_pipe_reg.sv - directed self-checking bench for exmem_pipe_reg
module tb_exmem_pipe_reg;

  logic clk, rst_n, hit, flush, in_valid;
  logic reg_write, mem_to_reg, mem_read, mem_write, branch, zero;
  logic [31:0] alu_res, write_data;
  logic [4:0]  reg_dst;

  logic        d2_valid, d2_rw, d2_m2r, d2_mr, d2_mw, d2_br, d2_z, d2_pcsrc;
  logic [31:0] d2_alu, d2_wd;
  logic [4:0]  d2_dst;
  logic [3:0]  d2_cnt;

  logic        d1_valid, d1_rw, d1_m2r, d1_mr, d1_mw, d1_br, d1_z, d1_pcsrc;
  logic [31:0] d1_alu, d1_wd;
  logic [4:0]  d1_dst;
  logic [15:0] d1_cnt;

  int n_checks = 0;
  int n_errors = 0;

  exmem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .STAGES(2), .STALL_CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush), .in_valid(in_valid),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .zero(zero),
    .alu_res(alu_res), .write_data(write_data), .reg_dst(reg_dst),
    .out_valid(d2_valid), .reg_write_out(d2_rw), .mem_to_reg_out(d2_m2r),
    .mem_read_out(d2_mr), .mem_write_out(d2_mw), .branch_out(d2_br), .zero_out(d2_z),
    .alu_res_out(d2_alu), .write_data_out(d2_wd), .reg_dst_out(d2_dst),
    .pcsrc(d2_pcsrc), .stall_cnt(d2_cnt)
  );

  exmem_pipe_reg u_dut1 (
    .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush), .in_valid(in_valid),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .zero(zero),
    .alu_res(alu_res), .write_data(write_data), .reg_dst(reg_dst),
    .out_valid(d1_valid), .reg_write_out(d1_rw), .mem_to_reg_out(d1_m2r),
    .mem_read_out(d1_mr), .mem_write_out(d1_mw), .branch_out(d1_br), .zero_out(d1_z),
    .alu_res_out(d1_alu), .write_data_out(d1_wd), .reg_dst_out(d1_dst),
    .pcsrc(d1_pcsrc), .stall_cnt(d1_cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic br, input logic z, input logic [31:0] alu,
                       input logic [4:0] dst);
    in_valid  = v;   reg_write = rw; mem_read = mr; mem_write = mw;
    branch    = br;  zero      = z;  alu_res  = alu; reg_dst  = dst;
    mem_to_reg = mr; write_data = ~alu;
  endtask

  initial begin
    rst_n = 1'b0; hit = 1'b1; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 5'd0);
    #12;
    check("reset_valid", d2_valid, 0);
    check("reset_alu", d2_alu, 0);
    check("reset_cnt", d2_cnt, 0);
    check("reset_pcsrc", d2_pcsrc, 0);
    rst_n = 1'b1;

    drive(1, 0, 0, 0, 0, 0, 32'h10, 5'd0);
    tick();
    check("lat_e1_valid", d2_valid, 0);
    check("lat_e1_alu", d2_alu, 0);
    check("lat_s1_alu", d1_alu, 32'h10);
    alu_res = 32'h20;
    tick();
    check("lat_e2_alu", d2_alu, 32'h10);
    check("lat_e2_valid", d2_valid, 1);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 5'd0);
    tick();
    check("lat_e3_alu", d2_alu, 32'h20);
    tick();
    check("lat_e4_valid", d2_valid, 0);

    drive(1, 0, 0, 1, 0, 0, 32'h0, 5'd7);
    tick();
    drive(1, 1, 0, 0, 0, 0, 32'h0, 5'd3);
    tick();
    check("stall_pre_mw", d2_mw, 1);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 5'd0);
    hit = 1'b0;
    repeat (3) tick();
    check("stall_mw", d2_mw, 1);
    check("stall_dst", d2_dst, 7);
    check("stall_valid", d2_valid, 1);
    check("stall_cnt3", d2_cnt, 3);
    hit = 1'b1;
    tick();
    check("adv_dst", d2_dst, 3);
    check("adv_mw", d2_mw, 0);
    check("adv_rw", d2_rw, 1);
    check("adv_cnt", d2_cnt, 3);

    drive(1, 1, 0, 1, 1, 1, 32'h44, 5'd9);
    tick();
    tick();
    check("br_pre_pcsrc", d2_pcsrc, 1);
    hit = 1'b0; flush = 1'b1;
    tick();
    check("fstall_pcsrc_hold", d2_pcsrc, 1);
    check("fstall_cnt4", d2_cnt, 4);
    flush = 1'b0;
    tick();
    check("fstall_cnt5", d2_cnt, 5);
    hit = 1'b1;
    tick();
    check("fkill_valid", d2_valid, 0);
    check("fkill_mw", d2_mw, 0);
    check("fkill_rw", d2_rw, 0);
    check("fkill_pcsrc", d2_pcsrc, 0);
    check("fkill_zero_ungated", d2_z, 1);
    check("fkill_dst_ungated", d2_dst, 9);
    check("fkill_s1_valid", d1_valid, 0);
    tick();
    check("fkill2_valid", d2_valid, 0);
    check("fkill2_s1_valid", d1_valid, 1);
    tick();
    check("br_pcsrc", d2_pcsrc, 1);
    check("br_branch_out", d2_br, 1);

    in_valid = 1'b0;
    tick();
    tick();
    check("bubble_pcsrc", d2_pcsrc, 0);
    check("bubble_branch_out", d2_br, 0);
    check("bubble_zero_out", d2_z, 1);

    hit = 1'b0;
    repeat (20) tick();
    check("sat_cnt4", d2_cnt, 15);
    check("sat_cnt16", d1_cnt, 25);
    hit = 1'b1;

    in_valid = 1'b1; flush = 1'b1;
    tick();
    check("fhit_s1_valid", d1_valid, 0);
    flush = 1'b0;
    tick();
    check("fhit_valid", d2_valid, 0);
    check("fhit_s1_next", d1_valid, 1);
    tick();
    check("fhit_recover", d2_valid, 1);

    drive(1, 1, 0, 1, 1, 1, 32'hDEADBEEF, 5'd5);
    tick();
    tick();
    check("pre_rst_alu", d2_alu, 32'hDEADBEEF);
    hit = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; hit = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", d2_valid, 0);
    check("rst_alu", d2_alu, 0);
    check("rst_wd", d2_wd, 0);
    check("rst_dst", d2_dst, 0);
    check("rst_zero", d2_z, 0);
    check("rst_pcsrc", d2_pcsrc, 0);
    check("rst_cnt", d2_cnt, 0);
    check("rst_s1_cnt", d1_cnt, 0);
    #3 rst_n = 1'b1;
    tick();
    check("rst_pend_s1_valid", d1_valid, 1);
    tick();
    check("rst_pend_valid", d2_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
